// File: rtl/rv_bus_pkg.sv
// rv_bus_pkg: shared burst encodings, FSM states and helpers for the memory bus target
package rv_bus_pkg;

    localparam logic [1:0] BURST_SINGLE = 2'b00;
    localparam logic [1:0] BURST_4      = 2'b01;
    localparam logic [1:0] BURST_8      = 2'b10;
    localparam logic [1:0] BURST_16     = 2'b11;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

    function automatic logic [4:0] burst_beats(input logic [1:0] burst);
        return burst == BURST_4  ? 5'd4  :
               burst == BURST_8  ? 5'd8  :
               burst == BURST_16 ? 5'd16 : 5'd1;
    endfunction

endpackage

// File: rtl/bus_sram.sv
// bus_sram: single-port 32-bit SRAM with byte write enables and a registered read
module bus_sram #(
  parameter int    ADDR_WIDTH = 14,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[addr];
  end
endmodule

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: wait-state, burst-capable SRAM target behind the instruction/data arbiter
module bus_mem_slave
    import rv_bus_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 14,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_burst,
    input  logic [3:0]  mem_bstrobe,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        mem_ready,
    output logic        mem_stall
);

    localparam int         LSB       = $clog2(WORD_BYTES);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [4:0]            beat_cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic                  wr;
    logic [3:0]            strobe;
    logic [3:0]            sram_we;
    logic [31:0]           sram_q;
    logic                  final_beat;
    logic                  unused_addr;

    assign req_addr    = mem_addr[ADDR_WIDTH+LSB-1:LSB];
    assign unused_addr = ^{mem_addr[31:ADDR_WIDTH+LSB], mem_addr[LSB-1:0]};
    assign final_beat  = beat_cnt == 5'd0;

    assign mem_ready     = state == S_BEAT;
    assign mem_read_data = (mem_ready && !wr) ? sram_q : '0;
    assign mem_stall     = (state == S_IDLE && mem_req) || state == S_WAIT || (mem_ready && !final_beat);

    // reads run one word ahead: the request address while idle, the first word while waiting,
    // the next word during read beats; write beats address the current word
    assign sram_addr = state == S_IDLE ? req_addr :
                       (state == S_WAIT || wr) ? addr : addr + 1'b1;
    assign sram_we   = {4{mem_ready && wr && !reset}} & strobe;

    bus_sram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clk  (clk),
        .addr (sram_addr),
        .we   (sram_we),
        .wdata(mem_write_data),
        .rdata(sram_q)
    );

    // request latch, wait countdown and beat sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            beat_cnt <= '0;
            addr     <= '0;
            wr       <= 1'b0;
            strobe   <= '0;
        end else begin
            case (state)
                S_IDLE: if (mem_req) begin
                    addr     <= req_addr;
                    wr       <= mem_write;
                    strobe   <= mem_bstrobe;
                    beat_cnt <= burst_beats(mem_burst) - 5'd1;
                    wait_cnt <= WAIT_STATES == 0 ? 4'd0 : WAIT_LAST;
                    state    <= WAIT_STATES == 0 ? S_BEAT : S_WAIT;
                end
                S_WAIT: if (wait_cnt == 4'd0) state <= S_BEAT;
                        else wait_cnt <= wait_cnt - 4'd1;
                S_BEAT: if (final_beat) state <= S_IDLE;
                        else begin
                            beat_cnt <= beat_cnt - 5'd1;
                            addr     <= addr + 1'b1;
                        end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_slave.sv
// tb_bus_mem_slave: scoreboard bench for bus_mem_slave with two parameterisations
module tb_bus_mem_slave;

    localparam int WS_A = 2;
    localparam int WS_B = 0;
    localparam int AW_A = 14;
    localparam int AW_B = 4;

    typedef struct {
        bit        is_wr;
        bit [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  burst = '0;
    logic [3:0]  strobe = '0;
    logic        a_req, b_req, a_ready, b_ready, a_stall, b_stall;
    logic [31:0] a_rd, b_rd;

    beat_t     q_a[$];
    beat_t     q_b[$];
    beat_t     ea, eb;
    bit [31:0] model_a[int];
    bit [31:0] model_b[int];
    int        checks = 0;
    int        passed = 0;

    assign a_req = req && !sel;
    assign b_req = req && sel;

    bus_mem_slave #(.ADDR_WIDTH(AW_A), .WAIT_STATES(WS_A), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(reset), .mem_req(a_req), .mem_write(wr), .mem_addr(addr),
        .mem_burst(burst), .mem_bstrobe(strobe), .mem_write_data(wdata),
        .mem_read_data(a_rd), .mem_ready(a_ready), .mem_stall(a_stall)
    );

    bus_mem_slave #(.ADDR_WIDTH(AW_B), .WAIT_STATES(WS_B), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(reset), .mem_req(b_req), .mem_write(wr), .mem_addr(addr),
        .mem_burst(burst), .mem_bstrobe(strobe), .mem_write_data(wdata),
        .mem_read_data(b_rd), .mem_ready(b_ready), .mem_stall(b_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void mwrite(input bit s, input int wa, input bit [31:0] d, input bit [3:0] st);
        bit [31:0] w;
        w = s ? (model_b.exists(wa) ? model_b[wa] : 32'h0) : (model_a.exists(wa) ? model_a[wa] : 32'h0);
        for (int i = 0; i < 4; i++)
            if (st[i]) w[8*i +: 8] = d[8*i +: 8];
        if (s) model_b[wa] = w;
        else model_a[wa] = w;
    endfunction

    function automatic bit [31:0] mread(input bit s, input int wa);
        return s ? model_b[wa] : model_a[wa];
    endfunction

    // monitors: every ready beat pops one expected beat
    always @(negedge clk) begin
        if (a_ready) begin
            if (q_a.size() == 0) check("a_unexpected_beat", 32'd1, 32'd0);
            else begin
                ea = q_a.pop_front();
                check(ea.is_wr ? "a_wbeat_rdata" : "a_read_data", a_rd, ea.is_wr ? 32'h0 : ea.data);
            end
        end
        if (b_ready) begin
            if (q_b.size() == 0) check("b_unexpected_beat", 32'd1, 32'd0);
            else begin
                eb = q_b.pop_front();
                check(eb.is_wr ? "b_wbeat_rdata" : "b_read_data", b_rd, eb.is_wr ? 32'h0 : eb.data);
            end
        end
    end

    // one burst on dut_a (s=0) or dut_b (s=1); abort_at >= 0 asserts reset during that beat
    task automatic txn(input bit s, input bit w, input logic [31:0] a, input logic [1:0] b,
                       input logic [3:0] st, input logic [31:0] d0, input int abort_at);
        int    ws, nb, mask, w0, last, wa;
        beat_t e;
        ws   = s ? WS_B : WS_A;
        nb   = b == 2'b00 ? 1 : b == 2'b01 ? 4 : b == 2'b10 ? 8 : 16;
        mask = s ? (1 << AW_B) - 1 : (1 << AW_A) - 1;
        w0   = int'(a >> 2) & mask;
        last = abort_at >= 0 ? abort_at : nb - 1;
        for (int k = 0; k <= last; k++) begin
            wa      = (w0 + k) & mask;
            e.is_wr = w;
            e.data  = 32'h0;
            if (w) begin
                if (k != abort_at) mwrite(s, wa, d0 + 32'(k), st);
            end else e.data = mread(s, wa);
            if (s) q_b.push_back(e);
            else q_a.push_back(e);
        end
        sel = s; wr = w; addr = a; burst = b; strobe = st; req = 1'b1;
        for (int c = 0; c <= ws + 1 + last; c++) begin
            if (c >= ws + 1) wdata = d0 + 32'(c - ws - 1);
            if (abort_at >= 0 && c == ws + 1 + abort_at) reset = 1'b1;
            @(negedge clk);
            check($sformatf("ready c%0d", c), s ? b_ready : a_ready, 32'(c >= ws + 1));
            check($sformatf("stall c%0d", c), s ? b_stall : a_stall, 32'(c != ws + nb));
            if (!(s ? b_ready : a_ready)) check($sformatf("rdata_idle c%0d", c), s ? b_rd : a_rd, 32'h0);
            @(posedge clk);
            #1;
            if (c == 0) req = 1'b0;
        end
        if (abort_at >= 0) begin
            reset = 1'b0;
            @(negedge clk);
            check("abort_ready", s ? b_ready : a_ready, 32'h0);
            check("abort_rdata", s ? b_rd : a_rd, 32'h0);
            check("abort_stall", s ? b_stall : a_stall, 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] exp_ready;
        logic [4:0] exp_stall;
        beat_t      e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset a_ready", a_ready, 32'h0);
        check("reset a_rdata", a_rd, 32'h0);
        check("reset a_stall", a_stall, 32'h0);
        check("reset b_ready", b_ready, 32'h0);
        check("reset b_stall", b_stall, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        txn(0, 1, 32'h10, 2'b00, 4'hF, 32'hDEADBEEF, -1);
        txn(0, 0, 32'h10, 2'b00, 4'hF, 32'h0, -1);
        txn(0, 1, 32'h20, 2'b00, 4'hF, 32'h11223344, -1);
        txn(0, 1, 32'h20, 2'b00, 4'h5, 32'hAABBCCDD, -1);
        txn(0, 0, 32'h20, 2'b00, 4'hF, 32'h0, -1);
        txn(0, 1, 32'h20, 2'b00, 4'h0, 32'hFFFFFFFF, -1);
        txn(0, 0, 32'h20, 2'b00, 4'hF, 32'h0, -1);
        txn(0, 1, 32'h100, 2'b10, 4'hF, 32'h1000, -1);
        txn(0, 0, 32'h100, 2'b10, 4'hF, 32'h0, -1);
        txn(0, 1, 32'h200, 2'b11, 4'hF, 32'h7000, -1);
        txn(0, 1, 32'h200, 2'b11, 4'hF, 32'h5000, 3);
        txn(0, 0, 32'h200, 2'b11, 4'hF, 32'h0, -1);
        txn(1, 1, 32'h38, 2'b01, 4'hF, 32'hA0, -1);
        txn(1, 0, 32'h38, 2'b00, 4'hF, 32'h0, -1);
        txn(1, 0, 32'h3C, 2'b00, 4'hF, 32'h0, -1);
        txn(1, 0, 32'h00, 2'b00, 4'hF, 32'h0, -1);
        txn(1, 0, 32'h04, 2'b00, 4'hF, 32'h0, -1);
        txn(1, 0, 32'h38, 2'b01, 4'hF, 32'h0, -1);
        e.is_wr = 1'b0;
        e.data  = model_b[14];
        q_b.push_back(e);
        e.data  = model_b[15];
        q_b.push_back(e);
        exp_ready = 5'b01010;
        exp_stall = 5'b00101;
        sel = 1'b1; wr = 1'b0; addr = 32'h38; burst = 2'b00; strobe = 4'hF; req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("b2b ready c%0d", c), b_ready, 32'(exp_ready[c]));
            check($sformatf("b2b stall c%0d", c), b_stall, 32'(exp_stall[c]));
            @(posedge clk);
            #1;
            if (c == 1) addr = 32'h3C;
            if (c == 2) req = 1'b0;
        end
        check("q_a drained", 32'(q_a.size()), 32'h0);
        check("q_b drained", 32'(q_b.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
